tt_pin_handshake_rx: RTL and testbench

Pin-level byte receiver that sits directly behind the Tiny Tapeout user-project pins and terminates the host-driven side of the chip interface. An external host (bench or board MCU) presents a byte on `ui_in` and runs a four-phase req/ack handshake on the bidirectional pins. Accepted bytes are buffered in a small FIFO. The host reads them back on `uo_out` and removes them with a pop strobe. All pin inputs are asynchronous to `clk` and are synchronized inside the block.

---
 rtl/tt_pin_handshake_rx.sv | 134 +++++++++++++
 tb/tb_tt_pin_handshake_rx.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tt_pin_handshake_rx.sv
// tt_pin_handshake_rx
// Pin-level byte receiver for a Tiny Tapeout user project. A host presents a
// byte on ui_in and runs a four-phase req/ack handshake on the bidirectional
// pins. Each accepted byte goes into a small FIFO. The host reads the head byte
// on uo_out and removes it with a pop strobe. req and pop are asynchronous to
// clk and pass through synchronizers inside this block.
//
// Ports
//   clk      system clock
//   rst_n    asynchronous active-low reset
//   ena      design selected; while low, no handshake or pop is started
//   ui_in    data byte from the host
//   uio_in   [0] req, [1] pop; other bits ignored
//   uo_out   FIFO head byte, 8'h00 when empty
//   uio_out  [3] ack, [4] empty, [5] full, [6] busy, [7] even parity of uo_out
//   uio_oe   constant 8'b1111_1000 (bits 7:3 driven)
module tt_pin_handshake_rx #(
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_ACK  = 1'b1
  } state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] req_sync_q, req_sync_d;
  logic [SYNC_STAGES-1:0] pop_sync_q, pop_sync_d;
  logic                   pop_last_q;
  logic [CNT_W-1:0]       count_q, count_d;
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [7:0]             mem_q [DEPTH];

  logic req_s, pop_s, pop_p;
  logic empty, full;
  logic wr_en, rd_en;
  logic ack, busy;
  logic unused_uio_in;

  // Only req and pop are meaningful on uio_in.
  assign unused_uio_in = &{1'b0, uio_in[7:2]};

  // Synchronizer chains: new sample enters at bit 0, synchronized value
  // leaves from the top bit.
  assign req_sync_d = {req_sync_q[SYNC_STAGES-2:0], uio_in[0]};
  assign pop_sync_d = {pop_sync_q[SYNC_STAGES-2:0], uio_in[1]};
  assign req_s      = req_sync_q[SYNC_STAGES-1];
  assign pop_s      = pop_sync_q[SYNC_STAGES-1];
  assign pop_p      = pop_s & ~pop_last_q;

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_FULL);

  // Handshake FSM. A full FIFO simply keeps the FSM in IDLE with ack low, so
  // the host holds its byte until space appears. ena is not consulted in ACK
  // so that an open handshake always completes.
  always_comb begin
    state_d = state_q;
    wr_en   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_s && ena && !full) begin
          wr_en   = 1'b1;
          state_d = S_ACK;
        end
      end
      S_ACK: begin
        if (!req_s) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign rd_en = pop_p & ena & ~empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = rd_en ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      req_sync_q <= '0;
      pop_sync_q <= '0;
      pop_last_q <= 1'b0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      req_sync_q <= req_sync_d;
      pop_sync_q <= pop_sync_d;
      pop_last_q <= pop_s;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // Storage needs no reset: the head is masked to zero whenever count is 0.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= ui_in;
  end

  assign ack     = (state_q == S_ACK);
  assign busy    = (state_q != S_IDLE);
  assign uo_out  = empty ? 8'h00 : mem_q[rd_ptr_q];
  assign uio_out = {^uo_out, busy, full, empty, ack, 3'b000};
  assign uio_oe  = 8'b1111_1000;

endmodule

// File: tb/tb_tt_pin_handshake_rx.sv
module tb_tt_pin_handshake_rx;

  localparam int DEPTH = 4;
  localparam int SYNC  = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int checks = 0;
  int errors = 0;

  // Reference model: the bytes the host expects to read back, oldest first.
  byte unsigned model_q[$];

  always #5 clk = ~clk;

  tt_pin_handshake_rx #(.DEPTH(DEPTH), .SYNC_STAGES(SYNC)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] model_head();
    return (model_q.size() != 0) ? model_q[0] : 8'h00;
  endfunction

  // Expected uio_out when the FSM state is known (ack_exp = handshake open).
  function automatic logic [7:0] model_status(input logic ack_exp);
    logic [7:0] h;
    h = model_head();
    return {^h, ack_exp, model_q.size() == DEPTH, model_q.size() == 0, ack_exp, 3'b000};
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Full four-phase write. lat = edges from first req sample to ack visible.
  task automatic do_write(input logic [7:0] d, output int lat);
    int n;
    ui_in     = d;
    uio_in[0] = 1'b1;
    n = 0;
    while (uio_out[3] !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (uio_out[3] !== 1'b1) begin
      errors++;
      $display("FAIL write_ack_timeout: ack=%b required 1 for data %h", uio_out[3], d);
      lat = -1;
    end else begin
      lat = n - 1;
      model_q.push_back(d);
    end
    uio_in[0] = 1'b0;
    n = 0;
    while (uio_out[3] !== 1'b0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (uio_out[3] !== 1'b0) begin
      errors++;
      $display("FAIL write_ack_release: ack=%b required 0", uio_out[3]);
    end
  endtask

  // Pop strobe, held long enough to cross the synchronizer, then settled.
  task automatic do_pop();
    uio_in[1] = 1'b1;
    cycles(SYNC + 1);
    uio_in[1] = 1'b0;
    cycles(SYNC + 2);
    if (ena && model_q.size() != 0) void'(model_q.pop_front());
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (model_q.size() != 0 && guard < 2 * DEPTH) begin
      checks++;
      if (uo_out !== model_head()) begin
        errors++;
        $display("FAIL drain_head: uo_out=%h required %h", uo_out, model_head());
      end
      do_pop();
      guard++;
    end
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    ena    = 1'b1;
    ui_in  = 8'h00;
    uio_in = 8'h00;
    cycles(3);
    rst_n = 1'b1;
    cycles(1);
    model_q.delete();
    checks++;
    if (uo_out !== 8'h00) begin errors++; $display("FAIL reset_uo_out: got %h required 00", uo_out); end
    checks++;
    if (uio_out !== 8'h10) begin errors++; $display("FAIL reset_uio_out: got %h required 10", uio_out); end
    checks++;
    if (uio_oe !== 8'hF8) begin errors++; $display("FAIL reset_uio_oe: got %h required f8", uio_oe); end
  endtask

  task automatic test_single();
    int lat;
    do_write(8'hA5, lat);
    checks++;
    if (lat != SYNC) begin errors++; $display("FAIL single_ack_latency: got %0d required %0d", lat, SYNC); end
    checks++;
    if (uo_out !== 8'hA5) begin errors++; $display("FAIL single_head: got %h required a5", uo_out); end
    checks++;
    if (uio_out[7] !== 1'b0) begin errors++; $display("FAIL single_parity: got %b required 0", uio_out[7]); end
    checks++;
    if (uio_out[4] !== 1'b0) begin errors++; $display("FAIL single_empty: got %b required 0", uio_out[4]); end
    do_pop();
    checks++;
    if (uo_out !== 8'h00) begin errors++; $display("FAIL single_after_pop: got %h required 00", uo_out); end
    checks++;
    if (uio_out[4] !== 1'b1) begin errors++; $display("FAIL single_empty_after_pop: got %b required 1", uio_out[4]); end
  endtask

  task automatic test_fill_backpressure();
    int lat;
    int n;
    for (int i = 1; i <= 4; i++) do_write(8'(i), lat);
    checks++;
    if (uio_out[5] !== 1'b1) begin errors++; $display("FAIL fill_full: got %b required 1", uio_out[5]); end
    checks++;
    if (uio_out !== model_status(1'b0)) begin
      errors++; $display("FAIL fill_status: got %h required %h", uio_out, model_status(1'b0));
    end
    ui_in     = 8'h05;
    uio_in[0] = 1'b1;
    cycles(10);
    checks++;
    if (uio_out[3] !== 1'b0) begin errors++; $display("FAIL backpressure_ack: got %b required 0", uio_out[3]); end
    do_pop();
    checks++;
    if (uio_out[3] !== 1'b1) begin
      errors++; $display("FAIL backpressure_release: ack=%b required 1", uio_out[3]);
    end else begin
      model_q.push_back(8'h05);
    end
    uio_in[0] = 1'b0;
    n = 0;
    while (uio_out[3] !== 1'b0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (uo_out !== 8'(8'h02 + i)) begin
        errors++; $display("FAIL fill_order_%0d: got %h required %h", i, uo_out, 8'(8'h02 + i));
      end
      do_pop();
    end
    checks++;
    if (uio_out !== 8'h10) begin errors++; $display("FAIL fill_drained: got %h required 10", uio_out); end
  endtask

  task automatic test_wrap();
    int lat;
    for (int i = 0; i < 10; i++) begin
      do_write(8'(8'h10 + i), lat);
      checks++;
      if (uo_out !== 8'(8'h10 + i)) begin
        errors++; $display("FAIL wrap_head_%0d: got %h required %h", i, uo_out, 8'(8'h10 + i));
      end
      do_pop();
      checks++;
      if (uio_out !== 8'h10) begin errors++; $display("FAIL wrap_empty_%0d: got %h required 10", i, uio_out); end
    end
  endtask

  task automatic test_random();
    int lat;
    int op;
    for (int i = 0; i < 40; i++) begin
      op = $urandom_range(0, 2);
      if (op != 0 && model_q.size() < DEPTH) do_write(8'($urandom_range(0, 255)), lat);
      else do_pop();
      checks++;
      if (uo_out !== model_head()) begin
        errors++; $display("FAIL random_head_%0d: got %h required %h", i, uo_out, model_head());
      end
      checks++;
      if (uio_out !== model_status(1'b0)) begin
        errors++; $display("FAIL random_status_%0d: got %h required %h", i, uio_out, model_status(1'b0));
      end
    end
    drain();
  endtask

  task automatic test_ena_gating();
    int lat;
    int n;
    do_write(8'h3C, lat);
    ena = 1'b0;
    do_pop();
    checks++;
    if (uo_out !== 8'h3C) begin errors++; $display("FAIL ena_pop_ignored: got %h required 3c", uo_out); end
    ui_in     = 8'hC3;
    uio_in[0] = 1'b1;
    cycles(8);
    checks++;
    if (uio_out[3] !== 1'b0 || uio_out[6] !== 1'b0) begin
      errors++; $display("FAIL ena_req_ignored: ack=%b busy=%b required 0 0", uio_out[3], uio_out[6]);
    end
    ena = 1'b1;
    n = 0;
    while (uio_out[3] !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (uio_out[3] !== 1'b1) begin
      errors++; $display("FAIL ena_pending_write: ack=%b required 1", uio_out[3]);
    end else begin
      model_q.push_back(8'hC3);
    end
    ena = 1'b0;
    cycles(2);
    uio_in[0] = 1'b0;
    n = 0;
    while (uio_out[3] !== 1'b0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (uio_out[3] !== 1'b0) begin errors++; $display("FAIL ena_ack_fall: ack=%b required 0", uio_out[3]); end
    ena = 1'b1;
    checks++;
    if (uio_out !== model_status(1'b0)) begin
      errors++; $display("FAIL ena_status: got %h required %h", uio_out, model_status(1'b0));
    end
    drain();
  endtask

  task automatic test_empty_pop();
    do_pop();
    checks++;
    if (uio_out !== 8'h10) begin errors++; $display("FAIL empty_pop_status: got %h required 10", uio_out); end
    checks++;
    if (uo_out !== 8'h00) begin errors++; $display("FAIL empty_pop_data: got %h required 00", uo_out); end
  endtask

  task automatic test_reset_mid();
    int n;
    int lat;
    do_write(8'h5A, lat);
    ui_in     = 8'h77;
    uio_in[0] = 1'b1;
    n = 0;
    while (uio_out[3] !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (uio_out[3] !== 1'b1) begin errors++; $display("FAIL mid_ack_before_reset: ack=%b required 1", uio_out[3]); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (uio_out[3] !== 1'b0) begin errors++; $display("FAIL mid_reset_ack: ack=%b required 0", uio_out[3]); end
    checks++;
    if (uio_out !== 8'h10) begin errors++; $display("FAIL mid_reset_count: uio_out=%h required 10", uio_out); end
    model_q.delete();
    uio_in[0] = 1'b0;
    cycles(2);
    rst_n = 1'b1;
    cycles(SYNC + 3);
    checks++;
    if (uio_out !== 8'h10 || uo_out !== 8'h00) begin
      errors++; $display("FAIL mid_after_release: uio_out=%h uo_out=%h required 10 00", uio_out, uo_out);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_backpressure();
    test_wrap();
    test_random();
    test_ena_gating();
    test_empty_pop();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
